// File: rtl/mpu_operand_loader.sv
// mpu_operand_loader
// Collects a signed 5x5 byte matrix (column-major, 25 transfers) followed by
// one signed scalar factor from a valid/ready byte stream, then presents both
// to the multiply stage until it acknowledges consumption.
module mpu_operand_loader (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic         clear,
  output logic [199:0] matrix_a,
  output logic [7:0]   factor,
  output logic         out_valid,
  input  logic         out_ack,
  output logic [4:0]   elem_count
);

  typedef enum logic [1:0] {
    LOAD_MATRIX = 2'd0,
    LOAD_FACTOR = 2'd1,
    HOLD        = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ELEM = 5'd24;

  state_t         state_r;
  state_t         state_s;
  logic [4:0]     count_r;
  logic [4:0]     count_s;
  logic           valid_r;
  logic           valid_s;
  logic [199:0]   matrix_r;
  logic [7:0]     factor_r;
  logic           xfer_s;
  logic           mat_we_s;
  logic           fac_we_s;

  // A byte is only accepted while loading; HOLD back-pressures upstream.
  // Reset also drops ready so nothing is offered as accepted while held.
  assign in_ready = (state_r != HOLD) && !reset;
  assign xfer_s   = in_valid && (state_r != HOLD);

  assign matrix_a   = matrix_r;
  assign factor     = factor_r;
  assign out_valid  = valid_r;
  assign elem_count = count_r;

  // Next-state, next-count and operand write enables; clear overrides all.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    valid_s  = valid_r;
    mat_we_s = 1'b0;
    fac_we_s = 1'b0;
    if (clear) begin
      state_s = LOAD_MATRIX;
      count_s = 5'd0;
      valid_s = 1'b0;
    end else begin
      case (state_r)
        LOAD_MATRIX: begin
          if (xfer_s) begin
            mat_we_s = 1'b1;
            count_s  = count_r + 5'd1;
            if (count_r == LAST_ELEM) begin
              state_s = LOAD_FACTOR;
            end else begin
              state_s = LOAD_MATRIX;
            end
          end else begin
            state_s = LOAD_MATRIX;
          end
        end
        LOAD_FACTOR: begin
          if (xfer_s) begin
            fac_we_s = 1'b1;
            state_s  = HOLD;
            valid_s  = 1'b1;
          end else begin
            state_s = LOAD_FACTOR;
          end
        end
        HOLD: begin
          if (out_ack) begin
            state_s = LOAD_MATRIX;
            count_s = 5'd0;
            valid_s = 1'b0;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = LOAD_MATRIX;
          count_s = 5'd0;
          valid_s = 1'b0;
        end
      endcase
    end
  end

  // Control state register: state, element counter and output-valid flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= LOAD_MATRIX;
      count_r <= 5'd0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      valid_r <= valid_s;
    end
  end

  // Operand storage: element k of the matrix lands at byte lane k, bit-exact.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      matrix_r <= 200'd0;
      factor_r <= 8'd0;
    end else if (clear) begin
      matrix_r <= 200'd0;
      factor_r <= 8'd0;
    end else begin
      if (fac_we_s) begin
        factor_r <= in_data;
      end
      for (int i = 0; i < 25; i++) begin
        if (mat_we_s && (count_r == 5'(i))) begin
          matrix_r[8*i +: 8] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpu_operand_loader.sv
// Self-checking bench for mpu_operand_loader: directed scenarios plus a
// randomized run, all compared against a byte-count based reference model.
module tb_mpu_operand_loader;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_ready;
  logic         clear = 1'b0;
  logic [199:0] matrix_a;
  logic [7:0]   factor;
  logic         out_valid;
  logic         out_ack = 1'b0;
  logic [4:0]   elem_count;

  int tests_run = 0;
  int failed    = 0;

  // Reference model: n = bytes accepted in this load (0..26); 26 means holding.
  int         mdl_n = 0;
  logic [7:0] mdl_mat [25];
  logic [7:0] mdl_fac = 8'd0;

  mpu_operand_loader dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear), .matrix_a(matrix_a), .factor(factor),
    .out_valid(out_valid), .out_ack(out_ack), .elem_count(elem_count)
  );

  always #5 clock = ~clock;

  function automatic logic [199:0] mdl_flat();
    logic [199:0] f;
    f = 200'd0;
    for (int i = 0; i < 25; i++) f[8*i +: 8] = mdl_mat[i];
    return f;
  endfunction

  function automatic logic [4:0] mdl_cnt();
    return (mdl_n > 25) ? 5'd25 : 5'(mdl_n);
  endfunction

  task automatic mdl_zero();
    mdl_n = 0;
    mdl_fac = 8'd0;
    for (int i = 0; i < 25; i++) mdl_mat[i] = 8'd0;
  endtask

  // Drive one cycle of inputs, advance the model, and land at posedge+1.
  task automatic step(input logic v, input logic [7:0] d, input logic clr, input logic ack);
    in_valid = v; in_data = d; clear = clr; out_ack = ack;
    if (clr) begin
      mdl_zero();
    end else if (mdl_n == 26) begin
      if (ack) mdl_n = 0;
    end else if (v) begin
      if (mdl_n < 25) mdl_mat[mdl_n] = d;
      else mdl_fac = d;
      mdl_n = mdl_n + 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || elem_count !== 5'd0 ||
        matrix_a !== 200'd0 || factor !== 8'd0) begin
      failed++;
      $display("FAIL reset_state: ready=%b valid=%b cnt=%0d fac=%h mat_nz=%b required 0s",
               in_ready, out_valid, elem_count, factor, |matrix_a);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    mdl_zero();
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_stream();
    logic [199:0] exp_mat;
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, 1'b0);
      tests_run++;
      if (elem_count !== 5'(i + 1) || out_valid !== 1'b0) begin
        failed++;
        $display("FAIL stream_count: cnt=%0d valid=%b required %0d/0", elem_count, out_valid, i + 1);
      end
    end
    tests_run++;
    if (in_ready !== 1'b1 || matrix_a[7:0] !== 8'd1) begin
      failed++;
      $display("FAIL stream_pre_factor: ready=%b e00=%h required 1/01", in_ready, matrix_a[7:0]);
    end
    step(1'b1, 8'hFD, 1'b0, 1'b0);
    exp_mat = 200'd0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++) exp_mat[8*(r + 5*c) +: 8] = 8'(r + 5*c + 1);
    tests_run++;
    if (out_valid !== 1'b1 || matrix_a !== exp_mat || factor !== 8'hFD || elem_count !== 5'd25 || in_ready !== 1'b0) begin
      failed++;
      $display("FAIL stream_done: valid=%b fac=%h cnt=%0d ready=%b mat=%h required 1/fd/25/0 mat=%h",
               out_valid, factor, elem_count, in_ready, matrix_a, exp_mat);
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);
    tests_run++;
    if (elem_count !== 5'd0 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL stream_ack: cnt=%0d valid=%b required 0/0", elem_count, out_valid);
    end
  endtask

  task automatic test_bubbles();
    int b;
    logic [7:0] d;
    b = 0;
    for (int i = 0; i < 52; i++) begin
      if (i % 2 == 0) begin
        d = (b < 25) ? 8'(b + 1) : 8'hFD;
        b++;
        step(1'b1, d, 1'b0, 1'b0);
      end else begin
        step(1'b0, 8'hEE, 1'b0, 1'b0);
      end
      tests_run++;
      if (elem_count !== ((b > 25) ? 5'd25 : 5'(b))) begin
        failed++;
        $display("FAIL bubble_count: cycle %0d cnt=%0d required %0d", i, elem_count, b);
      end
    end
    tests_run++;
    if (out_valid !== 1'b1 || factor !== 8'hFD || matrix_a[199:192] !== 8'd25 ||
        matrix_a[39:32] !== 8'd5 || matrix_a[47:40] !== 8'd6 || matrix_a !== mdl_flat()) begin
      failed++;
      $display("FAIL bubble_done: valid=%b fac=%h mat=%h required 1/fd", out_valid, factor, matrix_a);
    end
  endtask

  task automatic test_hold_ack();
    logic [199:0] held_mat;
    logic [7:0] held_fac;
    held_mat = matrix_a;
    held_fac = factor;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || elem_count !== 5'd25 ||
          matrix_a !== held_mat || factor !== held_fac) begin
        failed++;
        $display("FAIL hold_stable: ready=%b valid=%b cnt=%0d fac=%h required 0/1/25/%h",
                 in_ready, out_valid, elem_count, factor, held_fac);
      end
    end
    step(1'b1, 8'h55, 1'b0, 1'b1);
    tests_run++;
    if (elem_count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        matrix_a !== held_mat || factor !== held_fac) begin
      failed++;
      $display("FAIL hold_ack: cnt=%0d valid=%b ready=%b e00=%h required 0/0/1 operands kept",
               elem_count, out_valid, in_ready, matrix_a[7:0]);
    end
    step(1'b1, 8'h77, 1'b0, 1'b0);
    tests_run++;
    if (matrix_a[7:0] !== 8'h77 || elem_count !== 5'd1 || matrix_a[15:8] !== held_mat[15:8]) begin
      failed++;
      $display("FAIL ack_next_byte: e00=%h cnt=%0d required 77/1", matrix_a[7:0], elem_count);
    end
  endtask

  task automatic test_clear();
    while (mdl_n < 12) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
    tests_run++;
    if (elem_count !== 5'd12) begin
      failed++;
      $display("FAIL clear_setup: cnt=%0d required 12", elem_count);
    end
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    tests_run++;
    if (elem_count !== 5'd0 || matrix_a !== 200'd0 || factor !== 8'd0 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL clear_zero: cnt=%0d fac=%h mat=%h required all zero", elem_count, factor, matrix_a);
    end
    for (int i = 0; i < 26; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || matrix_a !== mdl_flat() || factor !== mdl_fac) begin
      failed++;
      $display("FAIL clear_reload: valid=%b fac=%h mat=%h required 1/%h mat=%h",
               out_valid, factor, matrix_a, mdl_fac, mdl_flat());
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (mdl_n != 26 && guard < 100) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      guard++;
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      failed++;
      $display("FAIL areset_setup: valid=%b required 1", out_valid);
    end
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || matrix_a !== 200'd0 || factor !== 8'd0 ||
        elem_count !== 5'd0 || in_ready !== 1'b0) begin
      failed++;
      $display("FAIL areset_immediate: valid=%b cnt=%0d fac=%h ready=%b required all 0",
               out_valid, elem_count, factor, in_ready);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    mdl_zero();
    for (int i = 0; i < 25; i++) step(1'b1, 8'h80, 1'b0, 1'b0);
    step(1'b1, 8'h7F, 1'b0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || matrix_a !== {25{8'h80}} || factor !== 8'h7F) begin
      failed++;
      $display("FAIL areset_reload: valid=%b fac=%h mat=%h required 1/7f all 80",
               out_valid, factor, matrix_a);
    end
    step(1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic v, clr, ack;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 99) < 2);
      ack = ($urandom_range(0, 9) < 3);
      step(v, 8'($urandom), clr, ack);
      tests_run++;
      if (elem_count !== mdl_cnt() || out_valid !== (mdl_n == 26) ||
          in_ready !== (mdl_n != 26) || factor !== mdl_fac || matrix_a !== mdl_flat()) begin
        failed++;
        $display("FAIL random_step %0d: cnt=%0d valid=%b ready=%b fac=%h required %0d/%b/%b/%h",
                 i, elem_count, out_valid, in_ready, factor, mdl_cnt(), mdl_n == 26, mdl_n != 26, mdl_fac);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_bubbles();
    test_hold_ack();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mpu_operand_loader.md
MPU_OPERAND_LOADER -- requirements
Module: mpu_operand_loader

Interface
REQ-001 Parameters: none; element width is fixed at 8 bits and the matrix at 5x5 (200-bit flattened bus).
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream byte available on in_data.
REQ-005 in_data  input  8  signed 8-bit operand byte.
REQ-006 in_ready  output  1  loader can accept a byte this cycle.
REQ-007 clear  input  1  synchronous abort of the current load.
REQ-008 matrix_a  output  200  signed flattened 5x5 matrix; element (col,row) at bits 8*(row+5*col) +: 8.
REQ-009 factor  output  8  signed scalar operand.
REQ-010 out_valid  output  1  matrix_a and factor are complete and stable.
REQ-011 out_ack  input  1  downstream multiply stage has consumed the operands.
REQ-012 elem_count  output  5  number of matrix elements accepted in the current load, 0..25.

Function
REQ-013 Transfer occurs on a rising clock edge when in_valid=1 and in_ready=1; no other condition writes operand registers.
REQ-014 FSM states: LOAD_MATRIX, LOAD_FACTOR, HOLD.
REQ-015 LOAD_MATRIX: transfer k (k = elem_count, 0..24) writes in_data to bits 8k+:8 of matrix_a and increments elem_count; the first five bytes fill col 0, rows 0..4.
REQ-016 LOAD_MATRIX -> LOAD_FACTOR on the transfer that brings elem_count to 25.
REQ-017 LOAD_FACTOR: one transfer writes in_data to factor; state -> HOLD; elem_count stays 25.
REQ-018 HOLD: out_valid=1; in_ready=0; matrix_a, factor and elem_count are held constant.
REQ-019 Latency: out_valid rises on the clock edge that accepts the factor byte, so it is visible the cycle after that byte is presented; minimum load time is 26 transfer cycles.
REQ-020 In HOLD, out_ack=1 at a clock edge moves the state to LOAD_MATRIX and sets elem_count to 0. matrix_a and factor keep their values until overwritten.
REQ-021 out_ack is ignored outside HOLD.
REQ-022 in_ready is 1 in LOAD_MATRIX and LOAD_FACTOR and 0 in HOLD. Since in_ready=0 in the ack cycle, no byte is accepted in that cycle; loading resumes the following cycle.
REQ-023 in_valid=0 cycles (bubbles) are permitted anywhere; state and data are unchanged.
REQ-024 clear=1 at a clock edge forces LOAD_MATRIX, elem_count=0, matrix_a=0, factor=0 and out_valid=0.
REQ-025 clear has priority over a simultaneous transfer and over out_ack; a byte presented in a clear cycle is dropped.
REQ-026 elem_count never exceeds 25 and never wraps.
REQ-027 Arithmetic: none; bytes are stored bit-exact with no sign extension or saturation.

Reset
REQ-028 While reset=1: state=LOAD_MATRIX, elem_count=0, matrix_a=0, factor=0, out_valid=0, in_ready=0.
REQ-029 Reset asserted mid-load or in HOLD discards the partial or complete operands immediately, without waiting for a clock edge.
REQ-030 After reset deasserts, in_ready=1 and the first accepted byte goes to element (0,0).

Verification
REQ-031 Stream bytes 1..25, then factor -3, with continuous in_valid -> out_valid=1 the cycle after the factor transfer; matrix_a[8*(row+5*col)+:8] = row+5*col+1; factor = 8'hFD.
REQ-032 Same stream with in_valid toggling every other cycle -> identical final outputs; elem_count increments only on transfer cycles.
REQ-033 Hold out_ack=0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0 and outputs unchanged; pulse out_ack -> elem_count=0 next cycle and the next byte lands in element (0,0).
REQ-034 Assert clear together with in_valid at elem_count=12 -> elem_count=0, matrix_a=0, factor=0, byte dropped; a following full load completes correctly.
REQ-035 Assert async reset between clock edges while in HOLD -> out_valid falls immediately, all outputs zero; after release, a full load of -128 x25 plus factor 127 yields all elements 8'h80 and factor 8'h7F.
